// File: rtl/keycode_pkg.sv
// Shared key codes, direction/fire-state types and direction priority helper.
// Optional build macro KEYCODE_AUTOFIRE_EN is consumed by player_input_ctrl.
package keycode_pkg;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, COOLDOWN = 2'd2} fire_state_t;

  // m = {left, down, right, up}; up has highest priority.
  function automatic dir_t prio_dir(input logic [3:0] m);
    if (m[0])      return UP;
    else if (m[1]) return RIGHT;
    else if (m[2]) return DOWN;
    else           return LEFT;
  endfunction
endpackage

// File: rtl/player_input_ctrl.sv
// One player's key decode: held/edge masks, last-pressed-wins heading, fire FSM.
// KEYCODE_AUTOFIRE_EN: fire key level (not edge) starts a request from IDLE.
module player_input_ctrl
  import keycode_pkg::*;
#(
  parameter logic [7:0] K_UP          = KEY_W,
  parameter logic [7:0] K_RIGHT       = KEY_D,
  parameter logic [7:0] K_DOWN        = KEY_S,
  parameter logic [7:0] K_LEFT        = KEY_A,
  parameter logic [7:0] K_FIRE        = KEY_J,
  parameter int         FIRE_COOLDOWN = 30,
  parameter int         CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] kc,
  input  logic        frame_tick,
  input  logic        fire_ack,
  output logic [1:0]  dir,
  output logic        move,
  output logic        fire_req
);
  function automatic logic hit(input logic [15:0] k, input logic [7:0] code);
    return (k[7:0] == code) || (k[15:8] == code);
  endfunction

  logic [4:0] held, rise, mask_q;  // {fire, left, down, right, up}
  logic [3:0] dheld;
  logic       fire_trig;
  dir_t        pend_q, pend_d, dir_q;
  logic        move_q;
  fire_state_t st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign held  = {hit(kc, K_FIRE), hit(kc, K_LEFT), hit(kc, K_DOWN),
                  hit(kc, K_RIGHT), hit(kc, K_UP)};
  assign rise  = held & ~mask_q;
  assign dheld = held[3:0];

`ifdef KEYCODE_AUTOFIRE_EN
  assign fire_trig = held[4];
`else
  assign fire_trig = rise[4];
`endif

  always_comb begin
    pend_d = pend_q;
    if (|rise[3:0])
      pend_d = prio_dir(rise[3:0]);
    else if (!dheld[pend_q] && |dheld)
      pend_d = prio_dir(dheld);
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: if (fire_trig) st_d = REQ;
      REQ: if (fire_ack) begin
        st_d  = COOLDOWN;
        cnt_d = CNT_W'(FIRE_COOLDOWN);
      end
      COOLDOWN: begin
        if (cnt_q == '0)     st_d  = IDLE;
        else if (frame_tick) cnt_d = cnt_q - CNT_W'(1);
      end
      default: st_d = IDLE;
    endcase
  end

  // Heading/move are committed only on frame_tick so they hold for a whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      pend_q <= UP;
      dir_q  <= UP;
      move_q <= 1'b0;
      st_q   <= IDLE;
      cnt_q  <= '0;
    end else begin
      mask_q <= held;
      pend_q <= pend_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      if (frame_tick) begin
        dir_q  <= pend_q;
        move_q <= |mask_q[3:0];
      end
    end
  end

  assign dir      = dir_q;
  assign move     = move_q;
  assign fire_req = (st_q == REQ);
endmodule

// File: rtl/keycode_dispatcher.sv
// Samples the 16-bit NIOS keycode word and fans it out to two player decoders.
// Optional build macro KEYCODE_AUTOFIRE_EN enables hold-to-repeat firing.
module keycode_dispatcher
  import keycode_pkg::*;
#(
  parameter int FIRE_COOLDOWN = 30,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keycode,
  input  logic        frame_tick,
  output logic [1:0]  p1_dir,
  output logic        p1_move,
  output logic        p1_fire_req,
  input  logic        p1_fire_ack,
  output logic [1:0]  p2_dir,
  output logic        p2_move,
  output logic        p2_fire_req,
  input  logic        p2_fire_ack
);
  logic [15:0] keycode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) keycode_q <= '0;
    else       keycode_q <= keycode;
  end

  player_input_ctrl #(
    .K_UP(KEY_W), .K_RIGHT(KEY_D), .K_DOWN(KEY_S), .K_LEFT(KEY_A), .K_FIRE(KEY_J),
    .FIRE_COOLDOWN(FIRE_COOLDOWN), .CNT_W(CNT_W)
  ) u_p1 (
    .clk(clk), .reset(reset), .kc(keycode_q), .frame_tick(frame_tick),
    .fire_ack(p1_fire_ack), .dir(p1_dir), .move(p1_move), .fire_req(p1_fire_req)
  );

  player_input_ctrl #(
    .K_UP(KEY_UP), .K_RIGHT(KEY_RIGHT), .K_DOWN(KEY_DOWN), .K_LEFT(KEY_LEFT),
    .K_FIRE(KEY_ENTER), .FIRE_COOLDOWN(FIRE_COOLDOWN), .CNT_W(CNT_W)
  ) u_p2 (
    .clk(clk), .reset(reset), .kc(keycode_q), .frame_tick(frame_tick),
    .fire_ack(p2_fire_ack), .dir(p2_dir), .move(p2_move), .fire_req(p2_fire_req)
  );
endmodule
